distance_stack: RTL and testbench

- Upstream feeder of the mark counters. Keeps one pairwise-distance hash slot per ruler level.
- Each slot holds the pdHash a mark counter produced when its position was accepted.
- Presents the OR of all slots below the active level as the `distances` vector a mark counter checks against.
- Commit/retract events arrive through a valid/ready handshake from the mark assembly. The merged result is produced sequentially with a valid flag.

---
 rtl/distance_stack_pkg.sv | 30 +++
 rtl/distance_stack_if.sv | 27 ++
 rtl/distance_stack_merge_unit.sv | 101 ++++++++++
 rtl/distance_stack.sv | 133 +++++++++++++
 tb/tb_distance_stack.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/distance_stack_pkg.sv
// distance_stack shared types: sizes, event kinds, FSM states.
// Optional build macro DIST_STACK_PARALLEL_MERGE_EN selects a one-cycle merge.
package distance_stack_pkg;

   localparam int NUM_POS   = 5;
   localparam int MAX_VALUE = 17;
   localparam int LVL_W     = 3;

   typedef logic [1:MAX_VALUE] hash_t;
   typedef logic [LVL_W-1:0]   lvl_t;
   typedef logic [LVL_W:0]     idx_t;

   typedef enum logic [1:0] {
      EV_COMMIT    = 2'b00,
      EV_RETRACT   = 2'b01,
      EV_CLEAR_ALL = 2'b10,
      EV_RSVD      = 2'b11
   } ev_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_APPLY = 2'b01,
      ST_MERGE = 2'b10
   } state_t;

   function automatic logic lvl_ok(input lvl_t l);
      return (l != '0) && (l <= lvl_t'(NUM_POS));
   endfunction

endpackage

// File: rtl/distance_stack_if.sv
// Event handshake and merged-distance result bundle of distance_stack.
// master = mark assembly side, slave = distance_stack side.
interface distance_stack_if;
   import distance_stack_pkg::*;

   logic     ev_valid;
   logic     ev_ready;
   ev_kind_t ev_kind;
   lvl_t     ev_level;
   hash_t    ev_hash;
   lvl_t     query_level;
   logic     dist_valid;
   hash_t    distances;
   logic     overlap_err;
   logic     level_err;

   modport master (
      output ev_valid, ev_kind, ev_level, ev_hash, query_level,
      input  ev_ready, dist_valid, distances, overlap_err, level_err
   );

   modport slave (
      input  ev_valid, ev_kind, ev_level, ev_hash, query_level,
      output ev_ready, dist_valid, distances, overlap_err, level_err
   );

endinterface

// File: rtl/distance_stack_merge_unit.sv
// Slot array plus masked OR merge of slots below the query level.
// DIST_STACK_PARALLEL_MERGE_EN: one-cycle OR instead of one slot per cycle.
module dist_merge_unit
   import distance_stack_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  logic     apply,
   input  ev_kind_t kind,
   input  lvl_t     level,
   input  hash_t    hash,
   input  logic     start,
   input  logic     step,
   input  lvl_t     q_level,
   output hash_t    result,
   output logic     last,
   output logic     overlap,
   output logic     bad_level
);

   hash_t slot [1:NUM_POS];
   hash_t below;
   logic  ok;

   always_comb begin
      ok    = lvl_ok(level);
      below = '0;
      for (int i = 1; i <= NUM_POS; i++) begin
         if (lvl_t'(i) < level) below = below | slot[i];
      end
      overlap   = apply && (kind == EV_COMMIT) && ok && (|(hash & below));
      bad_level = apply && !ok &&
                  ((kind == EV_COMMIT) || (kind == EV_RETRACT));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 1; i <= NUM_POS; i++) slot[i] <= '0;
      end else if (apply) begin
         for (int i = 1; i <= NUM_POS; i++) begin
            case (kind)
               EV_COMMIT: begin
                  if (ok && lvl_t'(i) == level) slot[i] <= hash;
                  else if (ok && lvl_t'(i) > level) slot[i] <= '0;
               end
               EV_RETRACT: begin
                  if (ok && lvl_t'(i) >= level) slot[i] <= '0;
               end
               EV_CLEAR_ALL: slot[i] <= '0;
               default: ;
            endcase
         end
      end
   end

`ifdef DIST_STACK_PARALLEL_MERGE_EN

   logic unused_ctl;
   assign unused_ctl = start ^ step;

   always_comb begin
      result = '0;
      for (int i = 1; i <= NUM_POS; i++) begin
         if (lvl_t'(i) < q_level) result = result | slot[i];
      end
      last = 1'b1;
   end

`else

   idx_t  idx;
   hash_t acc;
   hash_t pick;

   // result already includes the slot at idx, so it is the final value
   // on the cycle idx reaches NUM_POS
   always_comb begin
      pick = '0;
      for (int i = 1; i <= NUM_POS; i++) begin
         if (idx == idx_t'(i) && idx < {1'b0, q_level}) pick = slot[i];
      end
      result = acc | pick;
      last   = (idx == idx_t'(NUM_POS));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx <= idx_t'(1);
         acc <= '0;
      end else if (start) begin
         idx <= idx_t'(1);
         acc <= '0;
      end else if (step) begin
         idx <= idx + idx_t'(1);
         acc <= result;
      end
   end

`endif

endmodule

// File: rtl/distance_stack.sv
// Per-level pdHash stack with handshake FSM; merged distances for a level.
// DIST_STACK_PARALLEL_MERGE_EN selects a one-cycle merge in dist_merge_unit.
module distance_stack
   import distance_stack_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   distance_stack_if.slave  bus
);

   state_t   state;
   state_t   state_nx;
   ev_kind_t kind_q;
   lvl_t     level_q;
   hash_t    hash_q;
   lvl_t     q_lat;
   hash_t    dist_q;
   hash_t    result;
   logic     valid_q;
   logic     ready_q;
   logic     ovl_q;
   logic     lvl_q;
   logic     accept;
   logic     q_chg;
   logic     apply;
   logic     start;
   logic     step;
   logic     done;
   logic     last;
   logic     ovl;
   logic     bad;

   assign accept = bus.ev_valid && ready_q;
   assign q_chg  = (bus.query_level != q_lat);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_MERGE;
      else       state <= state_nx;
   end

   // an accepted event takes priority over a query_level change
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (accept)     state_nx = ST_APPLY;
            else if (q_chg) state_nx = ST_MERGE;
         end
         ST_APPLY: state_nx = ST_MERGE;
         ST_MERGE: begin
            if (accept)     state_nx = ST_APPLY;
            else if (q_chg) state_nx = ST_MERGE;
            else if (last)  state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      apply = 1'b0;
      start = 1'b0;
      step  = 1'b0;
      case (state)
         ST_IDLE:  start = !accept && q_chg;
         ST_APPLY: begin
            apply = 1'b1;
            start = 1'b1;
         end
         ST_MERGE: begin
            start = !accept && q_chg;
            step  = !accept && !q_chg;
         end
         default: ;
      endcase
      done = step && last;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         kind_q  <= EV_COMMIT;
         level_q <= '0;
         hash_q  <= '0;
         q_lat   <= '0;
         dist_q  <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         ovl_q   <= 1'b0;
         lvl_q   <= 1'b0;
      end else begin
         if (accept) begin
            kind_q  <= bus.ev_kind;
            level_q <= bus.ev_level;
            hash_q  <= bus.ev_hash;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
         end
         if (start) begin
            q_lat   <= bus.query_level;
            valid_q <= 1'b0;
         end
         if (done) begin
            dist_q  <= result;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
         end
         if (ovl) ovl_q <= 1'b1;
         if (bad) lvl_q <= 1'b1;
      end
   end

   dist_merge_unit u_merge (
      .clock     (clock),
      .reset     (reset),
      .apply     (apply),
      .kind      (kind_q),
      .level     (level_q),
      .hash      (hash_q),
      .start     (start),
      .step      (step),
      .q_level   (q_lat),
      .result    (result),
      .last      (last),
      .overlap   (ovl),
      .bad_level (bad)
   );

   assign bus.ev_ready    = ready_q;
   assign bus.dist_valid  = valid_q;
   assign bus.distances   = dist_q;
   assign bus.overlap_err = ovl_q;
   assign bus.level_err   = lvl_q;

endmodule

// File: tb/tb_distance_stack.sv
// Directed test of distance_stack: commit/retract/clear, errors, latency.
// Build with DIST_STACK_PARALLEL_MERGE_EN to check the one-cycle merge.
module tb_distance_stack;
   import distance_stack_pkg::*;

   logic clock = 1'b0;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;

`ifdef DIST_STACK_PARALLEL_MERGE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = NUM_POS + 1;
`endif

   always #5 clock = ~clock;

   distance_stack_if bif ();

   distance_stack dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic hash_t hs(input int a, input int b = 0,
                                input int c = 0);
      hash_t h;
      h = '0;
      if (a != 0) h[a] = 1'b1;
      if (b != 0) h[b] = 1'b1;
      if (c != 0) h[c] = 1'b1;
      return h;
   endfunction

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!bif.dist_valid && n < 40);
      chk({tag, "_valid"}, 32'(bif.dist_valid), 32'd1);
   endtask

   task automatic set_q(input lvl_t q, input string tag);
      @(negedge clock);
      bif.query_level = q;
      wait_valid(tag);
   endtask

   task automatic send(input ev_kind_t k, input lvl_t l, input hash_t h,
                       input string tag);
      int g;
      int lat;
      int low;
      @(negedge clock);
      bif.ev_valid = 1'b1;
      bif.ev_kind  = k;
      bif.ev_level = l;
      bif.ev_hash  = h;
      g = 0;
      while (!bif.ev_ready && g < 40) begin
         @(negedge clock);
         g++;
      end
      chk({tag, "_rdy"}, 32'(bif.ev_ready), 32'd1);
      @(posedge clock);
      #1;
      bif.ev_valid = 1'b0;
      chk({tag, "_rdy_drop"}, 32'(bif.ev_ready), 32'd0);
      lat = 0;
      low = 0;
      do begin
         @(posedge clock);
         #1;
         lat++;
         if (!bif.ev_ready) low++;
      end while (!bif.dist_valid && lat < 40);
      chk({tag, "_lat"}, 32'(lat), 32'(LAT));
      chk({tag, "_rdy_low"}, 32'(low), 32'(LAT - 1));
   endtask

   initial begin
      reset           = 1'b1;
      bif.ev_valid    = 1'b0;
      bif.ev_kind     = EV_COMMIT;
      bif.ev_level    = '0;
      bif.ev_hash     = '0;
      bif.query_level = 3'd2;
      #1;
      chk("rst_valid", 32'(bif.dist_valid), 32'd0);
      chk("rst_ready", 32'(bif.ev_ready), 32'd1);
      chk("rst_dist", 32'(bif.distances), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      wait_valid("boot");
      chk("boot_dist", 32'(bif.distances), 32'd0);
      chk("boot_ready", 32'(bif.ev_ready), 32'd1);
      chk("boot_errs", {30'd0, bif.overlap_err, bif.level_err}, 32'd0);

      send(EV_COMMIT, 3'd1, hs(1), "c1");
      chk("c1_dist", 32'(bif.distances), 32'(hs(1)));
      send(EV_COMMIT, 3'd2, hs(2, 3), "c2");
      set_q(3'd3, "q3");
      chk("q3_dist", 32'(bif.distances), 32'(hs(1, 2, 3)));
      set_q(3'd2, "q2");
      chk("q2_dist", 32'(bif.distances), 32'(hs(1)));
      set_q(3'd0, "q0");
      chk("q0_dist", 32'(bif.distances), 32'd0);
      set_q(3'd2, "q2b");

      send(EV_COMMIT, 3'd1, hs(3), "c1b");
      chk("c1b_dist", 32'(bif.distances), 32'(hs(3)));
      chk("c1b_ovl", 32'(bif.overlap_err), 32'd0);
      send(EV_COMMIT, 3'd2, hs(3), "c2b");
      chk("c2b_ovl", 32'(bif.overlap_err), 32'd1);
      set_q(3'd3, "q3b");
      chk("q3b_dist", 32'(bif.distances), 32'(hs(3)));

      send(EV_CLEAR_ALL, 3'd0, hs(4), "clr");
      chk("clr_dist", 32'(bif.distances), 32'd0);
      chk("clr_lerr", 32'(bif.level_err), 32'd0);
      send(EV_COMMIT, 3'd1, hs(1), "s1");
      send(EV_COMMIT, 3'd2, hs(5), "s2");
      send(EV_COMMIT, 3'd3, hs(7), "s3");
      set_q(3'd5, "q5");
      chk("q5_dist", 32'(bif.distances), 32'(hs(1, 5, 7)));
      set_q(3'd7, "q7");
      chk("q7_dist", 32'(bif.distances), 32'(hs(1, 5, 7)));
      set_q(3'd5, "q5b");
      send(EV_RETRACT, 3'd2, '0, "ret");
      chk("ret_dist", 32'(bif.distances), 32'(hs(1)));
      set_q(3'd1, "q1");
      chk("q1_dist", 32'(bif.distances), 32'd0);
      set_q(3'd5, "q5c");
      chk("q5c_dist", 32'(bif.distances), 32'(hs(1)));
      chk("ovl_sticky", 32'(bif.overlap_err), 32'd1);

      send(EV_COMMIT, 3'd0, hs(9), "bad0");
      chk("bad0_lerr", 32'(bif.level_err), 32'd1);
      chk("bad0_dist", 32'(bif.distances), 32'(hs(1)));
      send(EV_COMMIT, 3'd6, hs(9), "bad6");
      chk("bad6_lerr", 32'(bif.level_err), 32'd1);
      chk("bad6_dist", 32'(bif.distances), 32'(hs(1)));
      send(EV_CLEAR_ALL, 3'd3, '0, "clr2");
      chk("clr2_dist", 32'(bif.distances), 32'd0);

      send(EV_COMMIT, 3'd1, hs(2), "m1");
      @(negedge clock);
      bif.query_level = 3'd4;
      @(posedge clock);
      @(negedge clock);
      chk("mid_merge", 32'(bif.dist_valid), 32'd0);
      reset = 1'b1;
      #1;
      chk("mrst_valid", 32'(bif.dist_valid), 32'd0);
      chk("mrst_dist", 32'(bif.distances), 32'd0);
      chk("mrst_ready", 32'(bif.ev_ready), 32'd1);
      chk("mrst_errs", {30'd0, bif.overlap_err, bif.level_err}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      wait_valid("rboot");
      chk("rboot_dist", 32'(bif.distances), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
